// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared mode encodings and lane-slice helper for the pixel packer
package jpeg_pkg;

  localparam logic [1:0] MODE_TC2TC = 2'd0;
  localparam logic [1:0] MODE_SM2TC = 2'd1;
  localparam logic [1:0] MODE_TC2OB = 2'd2;
  localparam logic [1:0] MODE_SM2OB = 2'd3;

  localparam int BUS_MAX_W = 256;

  // Extracts lane idx of width w from a flattened bus, zero-extended to BUS_MAX_W.
  function automatic logic [BUS_MAX_W-1:0] lane_slice(input logic [BUS_MAX_W-1:0] bus,
                                                       input int idx, input int w);
    logic [BUS_MAX_W-1:0] mask;
    mask = {BUS_MAX_W{1'b1}} >> (BUS_MAX_W - w);
    return (bus >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/sat_lane.sv
// rtl/sat_lane.sv - combinational per-lane decode (stage 1) and clamp/offset (stage 2)
module sat_lane
  import jpeg_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]     i_raw,
  input  logic [1:0]          i_dec_mode,
  output logic signed [IN_W:0] o_dec,
  input  logic signed [IN_W:0] i_val,
  input  logic [1:0]          i_clamp_mode,
  output logic [OUT_W-1:0]    o_data,
  output logic                o_sat
);

  logic             w_is_sm;
  logic             w_is_ob;
  logic [IN_W-2:0]  w_mag;
  logic [OUT_W-1:0] w_clamped;
  logic             w_sat;

  assign w_is_sm = (i_dec_mode == MODE_SM2TC) || (i_dec_mode == MODE_SM2OB);
  assign w_is_ob = (i_clamp_mode == MODE_TC2OB) || (i_clamp_mode == MODE_SM2OB);
  assign w_mag   = i_raw[IN_W-2:0];

  // Negating a zero magnitude gives zero, so sign-magnitude -0 needs no special case.
  always_comb begin
    o_dec = '0;
    if (w_is_sm) begin
      if (i_raw[IN_W-1]) o_dec = -$signed({2'b00, w_mag});
      else               o_dec = $signed({2'b00, w_mag});
    end else begin
      o_dec = $signed({i_raw[IN_W-1], i_raw});
    end
  end

  generate
    if (OUT_W >= IN_W) begin : g_wide
      assign w_clamped = OUT_W'(i_val);
      assign w_sat     = 1'b0;
    end else begin : g_narrow
      localparam logic signed [IN_W:0] MAXV = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [IN_W:0] MINV = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        w_clamped = i_val[OUT_W-1:0];
        w_sat     = 1'b0;
        if (i_val > MAXV) begin
          w_clamped = MAXV[OUT_W-1:0];
          w_sat     = 1'b1;
        end else if (i_val < MINV) begin
          w_clamped = MINV[OUT_W-1:0];
          w_sat     = 1'b1;
        end
      end
    end
  endgenerate

  // Offset binary is the clamped two's-complement value with its MSB flipped.
  assign o_data = {w_clamped[OUT_W-1] ^ w_is_ob, w_clamped[OUT_W-2:0]};
  assign o_sat  = w_sat;

endmodule

// File: rtl/signed_pack_sat.sv
// rtl/signed_pack_sat.sv - multi-lane signed coefficient to pixel packer, 2-stage elastic pipe
module signed_pack_sat
  import jpeg_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 8,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_cnt
);

  logic                   r_s1_valid;
  logic [1:0]             r_s1_mode;
  logic signed [IN_W:0]   r_s1_val [LANES];
  logic                   r_out_valid;
  logic [LANES*OUT_W-1:0] r_out_data;
  logic [LANES-1:0]       r_out_sat;
  logic [CNT_W-1:0]       r_sat_cnt;

  logic [IN_W-1:0]        w_lane_in [LANES];
  logic signed [IN_W:0]   w_dec [LANES];
  logic [LANES*OUT_W-1:0] w_next_data;
  logic [LANES-1:0]       w_next_sat;
  logic                   w_s2_ready;
  logic                   w_s1_advance;
  logic                   w_out_fire;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      assign w_lane_in[g] = IN_W'(lane_slice(BUS_MAX_W'(in_data), g, IN_W));
      sat_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
        .i_raw        (w_lane_in[g]),
        .i_dec_mode   (in_mode),
        .o_dec        (w_dec[g]),
        .i_val        (r_s1_val[g]),
        .i_clamp_mode (r_s1_mode),
        .o_data       (w_next_data[g*OUT_W +: OUT_W]),
        .o_sat        (w_next_sat[g])
      );
    end
  endgenerate

  assign w_s2_ready   = !r_out_valid || out_ready;
  assign w_s1_advance = r_s1_valid && w_s2_ready;
  assign in_ready     = !r_s1_valid || w_s1_advance;
  assign w_out_fire   = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= '0;
      for (int i = 0; i < LANES; i++) r_s1_val[i] <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= in_mode;
        for (int i = 0; i < LANES; i++) r_s1_val[i] <= w_dec[i];
      end
    end
  end

  // Output registers only move when the downstream side can take a new beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= '0;
    end else if (w_s2_ready) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_next_data;
        r_out_sat  <= w_next_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (w_out_fire && (|r_out_sat) && (r_sat_cnt != {CNT_W{1'b1}})) begin
      r_sat_cnt <= r_sat_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign sat_cnt   = r_sat_cnt;

endmodule
